// File: rtl/ahb_tlul_bridge_pkg.sv
// rtl/ahb_tlul_bridge_pkg.sv - shared TL-UL / AHB encodings and bridge state type
package ahb_tlul_bridge_pkg;

   localparam logic [2:0] TL_GET              = 3'd4;
   localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
   localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WDATA,
      ST_REQ,
      ST_RESP,
      ST_ERR1,
      ST_ERR2
   } state_e;

endpackage

// File: rtl/ahb_tlul_bridge_tl_mask_gen.sv
// rtl/ahb_tlul_bridge_tl_mask_gen.sv - byte mask and alignment check from size and low address bits
module tl_mask_gen
   import ahb_tlul_bridge_pkg::*;
#(
   parameter int DBW = 4,
   parameter int OW  = $clog2(DBW)
) (
   input  logic [2:0]     size_i,
   input  logic [OW-1:0]  addr_i,
   output logic [DBW-1:0] mask_o,
   output logic           misaligned_o
);

   // A byte is enabled when it lies in the same size-aligned block as the address.
   always_comb begin
      mask_o       = '0;
      misaligned_o = 1'b0;
      for (int i = 0; i < DBW; i++) begin
         if ((i >> size_i) == (int'(addr_i) >> size_i)) mask_o[i] = 1'b1;
      end
      for (int b = 0; b < OW; b++) begin
         if ((b < int'(size_i)) && addr_i[b]) misaligned_o = 1'b1;
      end
   end

endmodule

// File: rtl/ahb_tlul_bridge.sv
// rtl/ahb_tlul_bridge.sv - AHB-Lite subordinate issuing one TL-UL request per single transfer
module ahb_tlul_bridge
   import ahb_tlul_bridge_pkg::*;
#(
   parameter int AHB_AW   = 32,
   parameter int AHB_DW   = 32,
   parameter int AHB_DS   = AHB_DW / 8,
   parameter int AHB_NM   = 8,
   parameter int TL_AW    = 32,
   parameter int TL_DW    = 32,
   parameter int TL_SRCW  = 8,
   parameter int TL_SINKW = 1,
   parameter int TL_DBW   = TL_DW / 8,
   parameter int TL_SZW   = $clog2($clog2(TL_DBW) + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                hsel_i,
   input  logic [AHB_AW-1:0]   haddr_i,
   input  logic [1:0]          htrans_i,
   input  logic                hwrite_i,
   input  logic [2:0]          hsize_i,
   input  logic [2:0]          hburst_i,
   input  logic [AHB_NM-1:0]   hmaster_i,
   input  logic [AHB_DW-1:0]   hwdata_i,
   input  logic [AHB_DS-1:0]   hwstrb_i,
   input  logic                hready_i,
   output logic                hreadyout_o,
   output logic                hresp_o,
   output logic [AHB_DW-1:0]   hrdata_o,
   output logic                a_valid_o,
   output logic [2:0]          a_opcode_o,
   output logic [2:0]          a_param_o,
   output logic [TL_SZW-1:0]   a_size_o,
   output logic [TL_SRCW-1:0]  a_source_o,
   output logic [TL_AW-1:0]    a_address_o,
   output logic [TL_DBW-1:0]   a_mask_o,
   output logic [TL_DW-1:0]    a_data_o,
   input  logic                a_ready_i,
   input  logic                d_valid_i,
   input  logic [2:0]          d_opcode_i,
   input  logic [2:0]          d_param_i,
   input  logic [TL_SZW-1:0]   d_size_i,
   input  logic [TL_SRCW-1:0]  d_source_i,
   input  logic [TL_SINKW-1:0] d_sink_i,
   input  logic [TL_DW-1:0]    d_data_i,
   input  logic                d_error_i,
   output logic                d_ready_o
);

   localparam int OW = $clog2(TL_DBW);

   state_e              state_q, state_d;
   logic                write_q, write_d;
   logic [TL_DBW-1:0]   smask_q, smask_d;
   logic                hreadyout_q, hreadyout_d;
   logic                hresp_q, hresp_d;
   logic [AHB_DW-1:0]   hrdata_q, hrdata_d;
   logic                a_valid_q, a_valid_d;
   logic [2:0]          a_opcode_q, a_opcode_d;
   logic [TL_SZW-1:0]   a_size_q, a_size_d;
   logic [TL_SRCW-1:0]  a_source_q, a_source_d;
   logic [TL_AW-1:0]    a_address_q, a_address_d;
   logic [TL_DBW-1:0]   a_mask_q, a_mask_d;
   logic [TL_DW-1:0]    a_data_q, a_data_d;
   logic                d_ready_q, d_ready_d;

   logic [TL_DBW-1:0]   gen_mask;
   logic                gen_misaligned;
   logic                accept;
   logic [TL_DBW-1:0]   wmask;
   logic                unused_inputs;

   assign unused_inputs = ^{hburst_i, d_param_i, d_size_i, d_sink_i, d_opcode_i};

   tl_mask_gen #(.DBW(TL_DBW)) u_mask_gen (
      .size_i       (hsize_i),
      .addr_i       (haddr_i[OW-1:0]),
      .mask_o       (gen_mask),
      .misaligned_o (gen_misaligned)
   );

   assign accept = ((state_q == ST_IDLE) || (state_q == ST_ERR2)) && hsel_i &&
                   ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ)) && hready_i;
   assign wmask  = smask_q & hwstrb_i;

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      smask_d     = smask_q;
      hreadyout_d = hreadyout_q;
      hresp_d     = hresp_q;
      hrdata_d    = hrdata_q;
      a_valid_d   = a_valid_q;
      a_opcode_d  = a_opcode_q;
      a_size_d    = a_size_q;
      a_source_d  = a_source_q;
      a_address_d = a_address_q;
      a_mask_d    = a_mask_q;
      a_data_d    = a_data_q;
      d_ready_d   = d_ready_q;
      unique case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
            if (accept) begin
               write_d     = hwrite_i;
               smask_d     = gen_mask;
               a_size_d    = hsize_i[TL_SZW-1:0];
               a_source_d  = TL_SRCW'(hmaster_i);
               a_address_d = TL_AW'(haddr_i);
               hreadyout_d = 1'b0;
               if ((int'(hsize_i) > OW) || gen_misaligned) begin
                  state_d = ST_ERR1;
                  hresp_d = HRESP_ERROR;
               end else if (hwrite_i) begin
                  state_d = ST_WDATA;
               end else begin
                  state_d    = ST_REQ;
                  a_valid_d  = 1'b1;
                  a_opcode_d = TL_GET;
                  a_mask_d   = gen_mask;
                  a_data_d   = '0;
               end
            end
         end
         ST_WDATA: begin
            a_mask_d = wmask;
            a_data_d = hwdata_i;
            // No enabled byte lanes: nothing to send downstream, finish the write here.
            if (wmask == '0) begin
               state_d     = ST_IDLE;
               hreadyout_d = 1'b1;
            end else begin
               state_d    = ST_REQ;
               a_valid_d  = 1'b1;
               a_opcode_d = ((a_size_q == TL_SZW'(OW)) && (&wmask)) ? TL_PUT_FULL_DATA
                                                                    : TL_PUT_PARTIAL_DATA;
            end
         end
         ST_REQ: begin
            if (a_ready_i) begin
               state_d   = ST_RESP;
               a_valid_d = 1'b0;
               d_ready_d = 1'b1;
            end
         end
         ST_RESP: begin
            if (d_valid_i) begin
               d_ready_d = 1'b0;
               if (d_error_i || (d_source_i != a_source_q)) begin
                  state_d = ST_ERR1;
                  hresp_d = HRESP_ERROR;
               end else begin
                  state_d     = ST_IDLE;
                  hreadyout_d = 1'b1;
                  hresp_d     = HRESP_OKAY;
                  if (!write_q) hrdata_d = d_data_i;
               end
            end
         end
         ST_ERR1: begin
            state_d     = ST_ERR2;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_ERROR;
         end
         default: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
            a_valid_d   = 1'b0;
            d_ready_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         write_q     <= 1'b0;
         smask_q     <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
         hrdata_q    <= '0;
         a_valid_q   <= 1'b0;
         a_opcode_q  <= '0;
         a_size_q    <= '0;
         a_source_q  <= '0;
         a_address_q <= '0;
         a_mask_q    <= '0;
         a_data_q    <= '0;
         d_ready_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         smask_q     <= smask_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
         hrdata_q    <= hrdata_d;
         a_valid_q   <= a_valid_d;
         a_opcode_q  <= a_opcode_d;
         a_size_q    <= a_size_d;
         a_source_q  <= a_source_d;
         a_address_q <= a_address_d;
         a_mask_q    <= a_mask_d;
         a_data_q    <= a_data_d;
         d_ready_q   <= d_ready_d;
      end
   end

   assign hreadyout_o = hreadyout_q;
   assign hresp_o     = hresp_q;
   assign hrdata_o    = hrdata_q;
   assign a_valid_o   = a_valid_q;
   assign a_opcode_o  = a_opcode_q;
   assign a_param_o   = 3'b000;
   assign a_size_o    = a_size_q;
   assign a_source_o  = a_source_q;
   assign a_address_o = a_address_q;
   assign a_mask_o    = a_mask_q;
   assign a_data_o    = a_data_q;
   assign d_ready_o   = d_ready_q;

endmodule
